gcd_sequencer: RTL and testbench

- Client-side driver for the binary GCD engine `gcd`.
- Accepts operand pairs on a valid/ready stream into a small FIFO, then presents each pair on the engine's ia/ib inputs.
- Tracks the engine's busy pulse, captures the result and returns {a, b, gcd, err} on a valid/ready output stream.
- Covers the engine's two limits: it recomputes only when its inputs change, and it has no result-valid strobe.

---
 rtl/gcd_pkg.sv | 15 +
 rtl/gcd_pair_fifo.sv | 53 +++++
 rtl/gcd_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_gcd_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD sequencer and the gcd engine it drives.
package gcd_pkg;

  // Operand/result width shared with the gcd engine.
  localparam int GCD_WIDTH = 7;

  // Sequencer FSM encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10,
    DONE   = 2'b11
  } seq_state_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Synchronous FIFO holding packed operand pairs; head is presented combinationally.
module gcd_pair_fifo
  import gcd_pkg::*;
#(
  parameter int width = 2 * GCD_WIDTH,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata,
  output logic [$clog2(depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because depth is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gcd_sequencer.sv
// Client-side driver for the gcd engine: queues operand pairs, launches the
// engine only when needed, covers its lack of a done strobe and its habit of
// not recomputing unchanged inputs, and returns results in order.
module gcd_sequencer
  import gcd_pkg::*;
#(
  parameter int width = GCD_WIDTH,
  parameter int depth = 4,
  parameter int tmo   = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_a,
  input  logic [width-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_a,
  output logic [width-1:0] out_b,
  output logic [width-1:0] out_gcd,
  output logic             out_err,
  output logic [width-1:0] ia,
  output logic [width-1:0] ib,
  input  logic             eng_busy,
  input  logic [width-1:0] eng_gcd
);

  localparam int CNT_W = $clog2(depth) + 1;
  localparam int TMR_W = $clog2(tmo) + 1;
  // The timeout fires on the edge where timer would reach tmo-1.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(tmo - 2);

  seq_state_t         state;
  seq_state_t         state_nx;
  logic [2*width-1:0] head;
  logic [width-1:0]   head_a;
  logic [width-1:0]   head_b;
  logic [width-1:0]   ha;
  logic [width-1:0]   hb;
  logic [width-1:0]   res;
  logic               res_err;
  logic [width-1:0]   cache_gcd;
  logic               cache_valid;
  logic [TMR_W-1:0]   timer;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               same_pair;
  logic               launch;
  logic               hit;
  logic               tmo_fire;
  logic               eng_done;
  logic               load_out;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && !fifo_full;
  assign head_a    = head[2*width-1:width];
  assign head_b    = head[width-1:0];
  assign same_pair = (head_a == ia) && (head_b == ib);

  gcd_pair_fifo #(
    .width (2 * width),
    .depth (depth)
  ) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (push),
    .pop   (pop),
    .wdata ({in_a, in_b}),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Occupancy and full flag must always agree.
  always_comb begin
    assert (fifo_full == (fifo_count == CNT_W'(depth)));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    launch   = 1'b0;
    hit      = 1'b0;
    tmo_fire = 1'b0;
    eng_done = 1'b0;
    load_out = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          // Unchanged inputs never restart the engine: serve from the cache,
          // or the trivial (0,0) pair that the engine was reset to.
          if (same_pair && (cache_valid || (head_a == '0 && head_b == '0))) begin
            hit      = 1'b1;
            state_nx = DONE;
          end else begin
            launch   = 1'b1;
            state_nx = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        if (eng_busy) begin
          state_nx = WAIT;
        end else if (timer == TMR_LAST) begin
          tmo_fire = 1'b1;
          state_nx = DONE;
        end
      end
      WAIT: begin
        // Engine updates its result on the same edge busy falls.
        if (!eng_busy) begin
          eng_done = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        // Hold the finished pair until the output register is free.
        if (!out_valid || out_ready) begin
          load_out = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Engine operands, result cache, launch timer and output register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ia          <= '0;
      ib          <= '0;
      cache_valid <= 1'b0;
      cache_gcd   <= '0;
      timer       <= '0;
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_gcd     <= '0;
      out_err     <= 1'b0;
    end else begin
      if (launch) begin
        ia          <= head_a;
        ib          <= head_b;
        timer       <= '0;
        cache_valid <= 1'b0;
      end else if (state == LAUNCH) begin
        timer <= timer + 1'b1;
      end
      if (eng_done) begin
        cache_gcd   <= eng_gcd;
        cache_valid <= 1'b1;
      end
      if (load_out) begin
        out_valid <= 1'b1;
        out_a     <= ha;
        out_b     <= hb;
        out_gcd   <= res;
        out_err   <= res_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Held pair and its pending result; always written before DONE reads them.
  always_ff @(posedge clk) begin
    if (pop) begin
      ha <= head_a;
      hb <= head_b;
    end
    if (hit) begin
      res     <= cache_valid ? cache_gcd : '0;
      res_err <= 1'b0;
    end else if (tmo_fire) begin
      res     <= '0;
      res_err <= 1'b1;
    end else if (eng_done) begin
      res     <= eng_gcd;
      res_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer: behavioural engine model, in-order scoreboard
// driven by a mathematical GCD, directed corner cases and a random phase.
module tb_gcd_sequencer;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst_ = 1'b0;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic [W-1:0] ia;
  logic [W-1:0] ib;
  logic         eng_busy;
  logic [W-1:0] eng_gcd;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         e;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  gcd_sequencer #(.width(W), .depth(4), .tmo(4)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_gcd   (out_gcd),
    .out_err   (out_err),
    .ia        (ia),
    .ib        (ib),
    .eng_busy  (eng_busy),
    .eng_gcd   (eng_gcd)
  );

  function automatic int gcd_ref(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string tag, input int got, input int want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Engine model: restarts only when ia/ib change, busy for eng_lat+1 cycles,
  // result updated on the edge busy falls. stuck suppresses the busy pulse.
  logic [W-1:0] eng_la;
  logic [W-1:0] eng_lb;
  int           eng_cnt;
  int           eng_lat = 3;
  bit           stuck = 1'b0;

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      eng_busy <= 1'b0;
      eng_gcd  <= '0;
      eng_la   <= '0;
      eng_lb   <= '0;
      eng_cnt  <= 0;
    end else if (eng_busy) begin
      if (eng_cnt == 0) begin
        eng_busy <= 1'b0;
        eng_gcd  <= W'(gcd_ref(int'(eng_la), int'(eng_lb)));
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end else if (ia != eng_la || ib != eng_lb) begin
      eng_la <= ia;
      eng_lb <= ib;
      if (!stuck) begin
        eng_busy <= 1'b1;
        eng_cnt  <= eng_lat;
      end
    end
  end

  // Count busy pulses so cache hits can be shown not to touch the engine.
  int   busy_rises = 0;
  logic busy_q = 1'b0;
  always @(negedge clk) begin
    if (eng_busy && !busy_q) busy_rises++;
    busy_q = eng_busy;
  end

  // Scoreboard: record accepted pairs, check every consumed result in order.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_) begin
      if (in_valid && in_ready) begin
        e.a = in_a;
        e.b = in_b;
        e.e = stuck;
        e.g = stuck ? '0 : W'(gcd_ref(int'(in_a), int'(in_b)));
        exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_extra", int'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_a", int'(out_a), int'(e.a));
          chk("out_b", int'(out_b), int'(e.b));
          chk("out_gcd", int'(out_gcd), int'(e.g));
          chk("out_err", int'(out_err), int'(e.e));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                      input int maxc, output bit ok);
    int n = 0;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!ok && n < maxc) begin
      #1;
      ok = in_ready;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
  endtask

  task automatic push_must(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    push(a, b, 50, ok);
    chk("push_accepted", int'(ok), 1);
  endtask

  task automatic wait_out(input int maxc, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    chk("out_valid_seen", int'(out_valid), 1);
  endtask

  task automatic wait_busy(input int maxc);
    int n = 0;
    while (!eng_busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("busy_seen", int'(eng_busy), 1);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int r0;
    int acc;
    int sent;
    int guard;
    int ov;
    bit ok;
    bit last_taken;
    logic [W-1:0] cap_a [7] = '{8, 9, 5, 16, 10, 14, 20};
    logic [W-1:0] cap_b [7] = '{12, 6, 3, 4, 15, 21, 30};

    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_a", int'(out_a), 0);
    chk("rst_out_b", int'(out_b), 0);
    chk("rst_out_gcd", int'(out_gcd), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_ia", int'(ia), 0);
    chk("rst_ib", int'(ib), 0);
    rst_ = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);

    // (0,0) straight after reset: served without launching the engine.
    r0 = busy_rises;
    push_must(0, 0);
    wait_out(20, cyc);
    chk("zero_latency", cyc, 2);
    chk("zero_no_busy", busy_rises - r0, 0);
    repeat (3) @(negedge clk);

    // Plain miss.
    push_must(12, 18);
    wait_busy(20);
    chk("miss_ia", int'(ia), 12);
    chk("miss_ib", int'(ib), 18);
    wait_out(40, cyc);
    repeat (3) @(negedge clk);

    // Miss then cache hit on identical pair.
    push_must(7, 7);
    wait_out(40, cyc);
    repeat (3) @(negedge clk);
    r0 = busy_rises;
    push_must(7, 7);
    wait_out(20, cyc);
    chk("hit_latency", cyc, 2);
    chk("hit_no_busy", busy_rises - r0, 0);
    repeat (3) @(negedge clk);

    // Capacity with the consumer stalled, then in-order release.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      push(cap_a[i], cap_b[i], 60, ok);
      if (ok) acc++;
    end
    chk("cap_accepted", acc, 6);
    chk("cap_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    drain(300);
    repeat (3) @(negedge clk);

    // Engine never raises busy: timeout, then the same pair relaunches.
    stuck = 1'b1;
    push_must(6, 4);
    wait_out(20, cyc);
    chk("tmo_latency", cyc, 5);
    repeat (3) @(negedge clk);
    push_must(6, 4);
    wait_out(20, cyc);
    chk("tmo_relaunch_latency", cyc, 5);
    repeat (3) @(negedge clk);
    stuck = 1'b0;

    // Reset while waiting on the engine: nothing stale may emerge.
    eng_lat = 6;
    push_must(48, 36);
    wait_busy(20);
    @(negedge clk);
    rst_ = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_ia", int'(ia), 0);
    chk("midrst_ib", int'(ib), 0);
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    ov = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    chk("midrst_no_stale", ov, 0);

    // Random traffic with random back-pressure and engine latency.
    sent       = 0;
    guard      = 0;
    last_taken = 1'b1;
    while (sent < 150 && guard < 20000) begin
      @(negedge clk);
      guard++;
      out_ready = ($urandom_range(0, 9) < 7);
      eng_lat   = int'($urandom_range(0, 5));
      if (!(in_valid && !last_taken)) begin
        if ($urandom_range(0, 9) == 0) begin
          in_a = '0;
          in_b = '0;
        end else if ($urandom_range(0, 3) != 0) begin
          in_a = W'($urandom_range(0, 60));
          in_b = W'($urandom_range(0, 60));
        end
        in_valid = ($urandom_range(0, 2) != 0);
      end
      #1;
      last_taken = in_valid && in_ready;
      if (last_taken) sent++;
    end
    chk("rand_sent", sent, 150);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(2000);
    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
